// File: rtl/tlb_refill.sv
// TLB refill engine: walks a multi-level page table on a miss and writes the
// translated entry into the set-associative TLB, or pulses a fault.
module tlb_refill #(
   parameter int ADDR    = 64,
   parameter int PAGE    = 12,
   parameter int PCID_B  = 12,
   parameter int WAY     = 8,
   parameter int SET_NUM = 8,
   parameter int LEVELS  = 4,
   parameter int IDX_B   = 9,
   localparam int VPN_W  = ADDR - PAGE,
   localparam int SET_W  = $clog2(SET_NUM),
   localparam int WAY_W  = (WAY > 1) ? $clog2(WAY) : 1,
   localparam int TAG_W  = VPN_W - SET_W,
   localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_valid,
   output logic              miss_ready,
   input  logic [VPN_W-1:0]  miss_vpn,
   input  logic [PCID_B-1:0] miss_pcid,
   input  logic [VPN_W-1:0]  ptbr,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR-1:0]   mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [63:0]       mem_resp_data,
   output logic              fill_valid,
   output logic [SET_W-1:0]  fill_set,
   output logic [WAY_W-1:0]  fill_way,
   output logic [TAG_W-1:0]  fill_tag,
   output logic [PCID_B-1:0] fill_pcid,
   output logic [VPN_W-1:0]  fill_ppn,
   output logic              fault_valid,
   output logic [LVL_W-1:0]  fault_level,
   output logic              busy
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_FAULT} state_t;

   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVELS - 1);
   localparam logic [WAY_W-1:0] WAY_ONE  = WAY_W'(1);

   state_t              state_q, state_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [VPN_W-1:0]    vpn_q, vpn_d;
   logic [PCID_B-1:0]   pcid_q, pcid_d;
   logic [VPN_W-1:0]    base_q, base_d;
   logic [VPN_W-1:0]    ppn_q, ppn_d;
   logic [SET_W-1:0]    set_q, set_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [WAY_W-1:0]    way_q, way_d;
   logic [PCID_B-1:0]   fpcid_q, fpcid_d;
   logic [LVL_W-1:0]    flvl_q, flvl_d;
   logic [WAY_W-1:0]    rr_q [SET_NUM];
   logic                rr_inc;
   logic [IDX_B-1:0]    req_idx;
   logic [VPN_W-1:0]    pte_ppn;
   logic                unused_pte;

   assign pte_ppn = mem_resp_data[ADDR-1:PAGE];

   // Level 0 consumes the most-significant VPN index field.
   always_comb req_idx = IDX_B'(vpn_q >> (IDX_B * (LEVELS - 1 - int'(level_q))));

   assign mem_req_addr = {base_q, {PAGE{1'b0}}} + ADDR'({req_idx, 3'b000});

   if (ADDR < 64) begin : g_hi
      assign unused_pte = ^{mem_resp_data[63:ADDR], mem_resp_data[PAGE-1:2]};
   end else begin : g_nohi
      assign unused_pte = ^mem_resp_data[PAGE-1:2];
   end

   always_comb begin
      state_d       = state_q;
      level_d       = level_q;
      vpn_d         = vpn_q;
      pcid_d        = pcid_q;
      base_d        = base_q;
      ppn_d         = ppn_q;
      set_d         = set_q;
      tag_d         = tag_q;
      way_d         = way_q;
      fpcid_d       = fpcid_q;
      flvl_d        = flvl_q;
      rr_inc        = 1'b0;
      miss_ready    = 1'b0;
      mem_req_valid = 1'b0;
      fill_valid    = 1'b0;
      fault_valid   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) begin
               vpn_d   = miss_vpn;
               pcid_d  = miss_pcid;
               base_d  = ptbr;
               level_d = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_resp_valid) begin
               if (!mem_resp_data[0]) begin
                  flvl_d  = level_q;
                  state_d = S_FAULT;
               end else if (mem_resp_data[1]) begin
                  // Fill fields are latched here so they hold after the strobe.
                  ppn_d   = pte_ppn;
                  set_d   = vpn_q[SET_W-1:0];
                  tag_d   = vpn_q[VPN_W-1:SET_W];
                  way_d   = rr_q[vpn_q[SET_W-1:0]];
                  fpcid_d = pcid_q;
                  rr_inc  = 1'b1;
                  state_d = S_FILL;
               end else if (level_q == LVL_LAST) begin
                  flvl_d  = level_q;
                  state_d = S_FAULT;
               end else begin
                  base_d  = pte_ppn;
                  level_d = level_q + LVL_ONE;
                  state_d = S_REQ;
               end
            end
         end
         S_FILL: begin
            fill_valid = 1'b1;
            state_d    = S_IDLE;
         end
         S_FAULT: begin
            fault_valid = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         level_q <= '0;
         vpn_q   <= '0;
         base_q  <= '0;
         ppn_q   <= '0;
         set_q   <= '0;
         tag_q   <= '0;
         way_q   <= '0;
         fpcid_q <= '0;
         flvl_q  <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         vpn_q   <= vpn_d;
         base_q  <= base_d;
         ppn_q   <= ppn_d;
         set_q   <= set_d;
         tag_q   <= tag_d;
         way_q   <= way_d;
         fpcid_q <= fpcid_d;
         flvl_q  <= flvl_d;
      end
   end

   always_ff @(posedge clk) pcid_q <= pcid_d;

   // Per-set victim pointer; WAY is a power of two so the add wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SET_NUM; s++) rr_q[s] <= '0;
      end else if (rr_inc) begin
         rr_q[vpn_q[SET_W-1:0]] <= rr_q[vpn_q[SET_W-1:0]] + WAY_ONE;
      end
   end

   assign fill_set    = set_q;
   assign fill_way    = way_q;
   assign fill_tag    = tag_q;
   assign fill_pcid   = fpcid_q;
   assign fill_ppn    = ppn_q;
   assign fault_level = flvl_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/tlb_refill.md
Name: tlb_refill

Overview:
- Fill engine on the write side of the set-associative TLB. It receives the TLB miss, walks a multi-level page table through a memory read port, and writes the translated entry into the TLB arrays.
- It supplies the set, way, tag, PCID and PPN the lookup side later compares against.
- Victim way is chosen by a per-set round-robin counter.
- A walk that ends on an invalid or malformed PTE raises a fault pulse instead of filling.

Parameters:
- ADDR, 64, virtual/physical address width in bits.
- PAGE, 12, page offset width in bits.
- PCID_B, 12, PCID width in bits.
- WAY, 8, ways per set (power of 2).
- SET_NUM, 8, number of sets (power of 2).
- LEVELS, 4, page-table levels (>=1).
- IDX_B, 9, VPN index bits per level. LEVELS*IDX_B must be <= ADDR-PAGE.

Ports:
- clk  in  1  clock, all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- miss_valid  in  1  miss request valid.
- miss_ready  out  1  engine idle, miss accepted when valid&ready.
- miss_vpn  in  ADDR-PAGE  missing virtual page number.
- miss_pcid  in  PCID_B  PCID of the miss.
- ptbr  in  ADDR-PAGE  root table PPN, sampled at miss accept.
- mem_req_valid  out  1  PTE read request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR  PTE byte address.
- mem_resp_valid  in  1  PTE data valid, single-cycle pulse.
- mem_resp_data  in  64  PTE.
- fill_valid  out  1  one-cycle TLB write strobe.
- fill_set  out  clog2(SET_NUM)  target set.
- fill_way  out  clog2(WAY)  target way.
- fill_tag  out  ADDR-PAGE-clog2(SET_NUM)  tag to store.
- fill_pcid  out  PCID_B  PCID to store.
- fill_ppn  out  ADDR-PAGE  physical page number.
- fault_valid  out  1  one-cycle walk-fault pulse.
- fault_level  out  clog2(LEVELS) (min 1)  level at which the fault occurred.
- busy  out  1  high in every state except IDLE.

Behaviour:

Reset:
- rst_n low asynchronously forces IDLE and clears all round-robin counters.
- All outputs reset to 0 except miss_ready, which is 1.

State machine (IDLE, REQ, WAIT, FILL, FAULT):
- IDLE: miss_ready=1. On miss_valid, capture vpn, pcid and ptbr into base; set level=0; go to REQ.
- REQ: mem_req_valid=1. mem_req_addr = {base, PAGE'b0} + (idx << 3), where idx = vpn[IDX_B*(LEVELS-level)-1 -: IDX_B]. Address is held stable until mem_req_ready. On the handshake, go to WAIT.
- WAIT: act on mem_resp_valid. PTE bit0 = valid, bit1 = leaf, bits[ADDR-1:PAGE] = PPN.
  - !valid -> FAULT.
  - valid & leaf -> FILL, latch fill_ppn = PTE[ADDR-1:PAGE].
  - valid & !leaf & level==LEVELS-1 -> FAULT.
  - Otherwise base = PTE PPN, level+1, go to REQ.
- FILL:
  - fill_valid=1 for exactly one cycle.
  - fill_set = vpn[clog2(SET_NUM)-1:0].
  - fill_tag = vpn[ADDR-PAGE-1:clog2(SET_NUM)].
  - fill_pcid = captured pcid.
  - fill_way = rr[fill_set].
  - rr[fill_set] increments, wrapping WAY-1 -> 0.
  - Next state IDLE.
- FAULT: fault_valid=1 for one cycle, fault_level = level. No fill, no counter change. Next state IDLE.

Output hold rules:
- fill_* and fault_level values are registered.
- They are defined only while the matching strobe is high, and hold their last value otherwise.

Boundary cases:
- mem_resp_valid outside WAIT, including the same cycle as the request handshake, is ignored.
- miss_valid during FILL/FAULT is not accepted; it is accepted in the following IDLE cycle.
- Reset mid-walk aborts the walk with no fill or fault. A late response arriving in IDLE is ignored.
- Minimum latency, leaf at level 0 with zero-wait memory: accept at T, request handshake T+1, response T+2, fill_valid at T+3.
- Each extra level adds 2 cycles.
- One walk is outstanding at a time.

Test Plan:
1. LEVELS=4, ptbr=0x100, vpn=0x12345, pcid=0x7. Expect mem_req_addr=0x100000. Respond PTE 0xABCD003 -> fill_valid at T+3 with fill_ppn=0xABCD, fill_set=5, fill_tag=0x2468, fill_pcid=0x7, fill_way=0.
2. Same miss, full walk with PTEs 0x200001, 0x300001, 0x400001, 0x777003. Expect request addrs 0x100000, 0x200000, 0x300488, 0x400A28, then fill_ppn=0x777.
3. PTE0=0x200001, PTE1=0x0. Expect fault_valid=1 for one cycle with fault_level=1, no fill_valid, busy low the next cycle.
4. Nine successful leaf-at-level-0 misses all with vpn[2:0]=3 -> fill_way sequence 0,1,2,3,4,5,6,7,0. A miss to set 4 in between gets way 0.
5. Hold mem_req_ready low 5 cycles and pulse mem_resp_valid during REQ. Expect mem_req_addr stable, the pulse ignored, and the walk completing normally after ready.
6. Assert rst_n low during WAIT, release, then send the stale response. Expect all outputs 0, miss_ready=1, no fill/fault, and the next fill in set 5 using way 0.
